spio_hss_multiplexer_frame_rx: RTL and testbench

SPIO_HSS_MULTIPLEXER_FRAME_RX -- requirements
Module: spio_hss_multiplexer_frame_rx

---
 rtl/spio_hss_multiplexer_pkg.sv | 70 +++++++
 rtl/spio_hss_multiplexer_crc16_w32.sv | 36 +++
 rtl/spio_hss_multiplexer_frame_rx.sv | 168 ++++++++++++++++
 tb/tb_spio_hss_multiplexer_frame_rx.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spio_hss_multiplexer_pkg.sv
// ============================================================================
// Module : spio_hss_multiplexer_pkg
// Purpose: Shared definitions for the SpiNNaker HSS link multiplexer blocks.
//          It holds the link word and K-flag widths, the framing control
//          characters, the K-flag patterns, the CRC polynomial, the word-class
//          and receiver-state enums, and a helper that classifies one link
//          word.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package spio_hss_multiplexer_pkg;

  // Link word geometry
  localparam int FRM_BITS = 32;
  localparam int KCH_BITS = 4;

  // Control characters carried in byte 0 of a K-flagged word
  localparam logic [7:0] SOF_CHR  = 8'hFB;  // K27.7
  localparam logic [7:0] EOF_CHR  = 8'hFD;  // K29.7
  localparam logic [7:0] IDLE_CHR = 8'hBC;  // K28.5

  // Per-byte K-flag patterns
  localparam logic [KCH_BITS-1:0] KCH_NONE = 4'b0000;
  localparam logic [KCH_BITS-1:0] KCH_CTRL = 4'b0001;
  localparam logic [KCH_BITS-1:0] KCH_CLKC = 4'b1111;

  // CRC-16-CCITT generator
  localparam logic [15:0] CRC_POLY = 16'h1021;

  typedef enum logic [2:0] {
    WCLS_PAYLOAD = 3'd0,
    WCLS_SOF     = 3'd1,
    WCLS_EOF     = 3'd2,
    WCLS_IDLE    = 3'd3,
    WCLS_CLKC    = 3'd4,
    WCLS_BAD     = 3'd5
  } word_cls_e;

  typedef enum logic {
    ST_HUNT    = 1'b0,
    ST_PAYLOAD = 1'b1
  } rx_state_e;

  // Decode one link word into its class. Any K-flag pattern other than the
  // three recognised ones, or an unknown control character, is BAD.
  function automatic word_cls_e classify_word(
    input logic [FRM_BITS-1:0] data,
    input logic [KCH_BITS-1:0] kchr
  );
    word_cls_e cls;
    cls = WCLS_BAD;
    if (kchr == KCH_NONE) begin
      cls = WCLS_PAYLOAD;
    end else if (kchr == KCH_CLKC) begin
      cls = WCLS_CLKC;
    end else if (kchr == KCH_CTRL) begin
      case (data[7:0])
        SOF_CHR:  cls = WCLS_SOF;
        EOF_CHR:  cls = WCLS_EOF;
        IDLE_CHR: cls = WCLS_IDLE;
        default:  cls = WCLS_BAD;
      endcase
    end
    return cls;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spio_hss_multiplexer_crc16_w32.sv
// ============================================================================
// Module : spio_hss_multiplexer_crc16_w32
// Purpose: Combinational CRC-16-CCITT next-state over one 32-bit word,
//          processed MSB first, no reflection.
// Ports  : crc_in  [15:0] current CRC
//          data    [31:0] word to fold in
//          crc_out [15:0] CRC after the word
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spio_hss_multiplexer_crc16_w32
  import spio_hss_multiplexer_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [31:0] data,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 31; i >= 0; i--) begin
      if (c[15] ^ data[i]) begin
        c = {c[14:0], 1'b0} ^ CRC_POLY;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    crc_out = c;
  end

endmodule

`default_nettype wire

// File: rtl/spio_hss_multiplexer_frame_rx.sv
// ============================================================================
// Module : spio_hss_multiplexer_frame_rx
// Purpose: Frame receiver for the HSS link multiplexer. It hunts for SOF,
//          collects payload words with a one-word delay buffer so the last
//          word can be tagged, checks the CRC-16 carried by EOF, aborts on
//          overlength or unexpected control words, and records the idle
//          sentinel.
// Ports  : clk, rst (async, active-low)
//          hsl_data/hsl_kchr/hsl_vld  received link word, no backpressure
//          frm_data/frm_vld/frm_last  payload stream out
//          frm_crce/frm_frme          status, valid with frm_last
//          reg_dfrm/reg_crce/reg_frme one-cycle event pulses
//          reg_idsi                   last idle sentinel
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spio_hss_multiplexer_frame_rx
  import spio_hss_multiplexer_pkg::*;
#(
  parameter int          FRM_MAX_WORDS = 16,
  parameter logic [15:0] CRC_INIT      = 16'hFFFF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [FRM_BITS-1:0] hsl_data,
  input  logic [KCH_BITS-1:0] hsl_kchr,
  input  logic                hsl_vld,
  output logic [FRM_BITS-1:0] frm_data,
  output logic                frm_vld,
  output logic                frm_last,
  output logic                frm_crce,
  output logic                frm_frme,
  output logic                reg_dfrm,
  output logic                reg_crce,
  output logic                reg_frme,
  output logic [15:0]         reg_idsi
);

  localparam logic [4:0] MAX_CNT = 5'(FRM_MAX_WORDS);

  rx_state_e           state;
  logic [4:0]          cnt;
  logic [15:0]         crc;
  logic [FRM_BITS-1:0] buf_data;

  word_cls_e           cls;
  logic                act;
  logic                abort;
  logic                buf_full;
  logic [15:0]         crc_next;

  spio_hss_multiplexer_crc16_w32 u_crc (
    .crc_in  (crc),
    .data    (hsl_data),
    .crc_out (crc_next)
  );

  // CLKC words and idle link cycles are invisible to the receiver.
  always_comb begin
    cls      = classify_word(hsl_data, hsl_kchr);
    act      = hsl_vld && (cls != WCLS_CLKC);
    // The buffer holds a word exactly when at least one payload word has
    // been accepted in the current frame.
    buf_full = (cnt != 5'd0);
    abort    = 1'b0;
    if (act && (state == ST_PAYLOAD)) begin
      case (cls)
        WCLS_PAYLOAD: abort = (cnt >= MAX_CNT);
        WCLS_SOF,
        WCLS_IDLE,
        WCLS_BAD:     abort = 1'b1;
        default:      abort = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_HUNT;
      cnt      <= 5'd0;
      crc      <= CRC_INIT;
      buf_data <= '0;
      frm_data <= '0;
      frm_vld  <= 1'b0;
      frm_last <= 1'b0;
      frm_crce <= 1'b0;
      frm_frme <= 1'b0;
      reg_dfrm <= 1'b0;
      reg_crce <= 1'b0;
      reg_frme <= 1'b0;
      reg_idsi <= 16'h0000;
    end else begin
      // Event outputs are single-cycle by construction.
      frm_vld  <= 1'b0;
      frm_last <= 1'b0;
      frm_crce <= 1'b0;
      frm_frme <= 1'b0;
      reg_dfrm <= 1'b0;
      reg_crce <= 1'b0;
      reg_frme <= 1'b0;

      // The sentinel is captured in either state, even when the IDLE word
      // aborts a frame.
      if (act && (cls == WCLS_IDLE)) begin
        reg_idsi <= hsl_data[31:16];
      end

      if (abort) begin
        if (buf_full) begin
          frm_data <= buf_data;
          frm_vld  <= 1'b1;
          frm_last <= 1'b1;
          frm_frme <= 1'b1;
        end
        reg_frme <= 1'b1;
        cnt      <= 5'd0;
        crc      <= CRC_INIT;
        // An SOF that aborts the current frame also opens the next one.
        state    <= (cls == WCLS_SOF) ? ST_PAYLOAD : ST_HUNT;
      end else if (act) begin
        case (state)
          ST_HUNT: begin
            if (cls == WCLS_SOF) begin
              state <= ST_PAYLOAD;
              cnt   <= 5'd0;
              crc   <= CRC_INIT;
            end
          end

          ST_PAYLOAD: begin
            if (cls == WCLS_PAYLOAD) begin
              if (buf_full) begin
                frm_data <= buf_data;
                frm_vld  <= 1'b1;
              end
              buf_data <= hsl_data;
              cnt      <= cnt + 5'd1;
              crc      <= crc_next;
            end else if (cls == WCLS_EOF) begin
              if (buf_full) begin
                frm_data <= buf_data;
                frm_vld  <= 1'b1;
                frm_last <= 1'b1;
                if (crc != hsl_data[31:16]) begin
                  frm_crce <= 1'b1;
                  reg_crce <= 1'b1;
                end else begin
                  reg_dfrm <= 1'b1;
                end
              end else begin
                reg_frme <= 1'b1;
              end
              cnt   <= 5'd0;
              crc   <= CRC_INIT;
              state <= ST_HUNT;
            end
          end

          default: state <= ST_HUNT;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spio_hss_multiplexer_frame_rx.sv
// ============================================================================
// Module : tb_spio_hss_multiplexer_frame_rx
// Purpose: Self-checking bench for spio_hss_multiplexer_frame_rx. A frame
//          reference model (word queue plus whole-frame CRC) predicts every
//          output cycle; directed scenarios add event-count checks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spio_hss_multiplexer_frame_rx;
  import spio_hss_multiplexer_pkg::*;

  localparam int          MAXW = 16;
  localparam logic [15:0] CINIT = 16'hFFFF;

  logic        clk;
  logic        rst;
  logic [31:0] hsl_data;
  logic [3:0]  hsl_kchr;
  logic        hsl_vld;
  logic [31:0] frm_data;
  logic        frm_vld, frm_last, frm_crce, frm_frme;
  logic        reg_dfrm, reg_crce, reg_frme;
  logic [15:0] reg_idsi;

  spio_hss_multiplexer_frame_rx #(
    .FRM_MAX_WORDS (MAXW),
    .CRC_INIT      (CINIT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .hsl_data (hsl_data),
    .hsl_kchr (hsl_kchr),
    .hsl_vld  (hsl_vld),
    .frm_data (frm_data),
    .frm_vld  (frm_vld),
    .frm_last (frm_last),
    .frm_crce (frm_crce),
    .frm_frme (frm_frme),
    .reg_dfrm (reg_dfrm),
    .reg_crce (reg_crce),
    .reg_frme (reg_frme),
    .reg_idsi (reg_idsi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Observed event counters for directed scenarios
  int o_vld, o_last, o_crce, o_frme, o_dfrm, o_rcrce, o_rfrme;

  // Reference model state
  bit          m_in_frame;
  logic [31:0] m_q[$];
  logic [31:0] e_data;
  logic        e_vld, e_last, e_crce, e_frme, e_dfrm, e_rcrce, e_rfrme;
  logic [15:0] e_idsi;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // CRC-16-CCITT over a whole list of words, MSB first.
  function automatic logic [15:0] crc_of(input logic [31:0] words[$]);
    logic [15:0] c;
    c = CINIT;
    foreach (words[w]) begin
      for (int b = 31; b >= 0; b--) begin
        c = {c[14:0], 1'b0} ^ (((c[15] ^ words[w][b]) == 1'b1) ? 16'h1021 : 16'h0000);
      end
    end
    return c;
  endfunction

  function automatic logic [31:0] mk_ctrl(input logic [15:0] hi, input logic [7:0] chr);
    return {hi, 8'h00, chr};
  endfunction

  task automatic model_reset();
    m_in_frame = 0;
    m_q.delete();
    e_data = '0; e_vld = 0; e_last = 0; e_crce = 0; e_frme = 0;
    e_dfrm = 0; e_rcrce = 0; e_rfrme = 0; e_idsi = '0;
  endtask

  task automatic model_emit(input logic last, input logic frme);
    e_data = m_q[$];
    e_vld  = 1;
    e_last = last;
    e_frme = frme;
  endtask

  // Predicts the outputs that follow one input cycle.
  task automatic model_step(input logic [31:0] d, input logic [3:0] k, input logic v);
    bit is_pl, is_sof, is_eof, is_idle, is_clkc;
    e_vld = 0; e_last = 0; e_crce = 0; e_frme = 0;
    e_dfrm = 0; e_rcrce = 0; e_rfrme = 0;
    if (!v) return;
    is_pl   = (k == 4'b0000);
    is_clkc = (k == 4'b1111);
    is_sof  = (k == 4'b0001) && (d[7:0] == SOF_CHR);
    is_eof  = (k == 4'b0001) && (d[7:0] == EOF_CHR);
    is_idle = (k == 4'b0001) && (d[7:0] == IDLE_CHR);
    if (is_clkc) return;
    if (is_idle) e_idsi = d[31:16];
    if (!m_in_frame) begin
      if (is_sof) begin
        m_in_frame = 1;
        m_q.delete();
      end
      return;
    end
    if (is_pl && (m_q.size() < MAXW)) begin
      if (m_q.size() > 0) model_emit(0, 0);
      m_q.push_back(d);
    end else if (is_eof) begin
      if (m_q.size() == 0) begin
        e_rfrme = 1;
      end else begin
        model_emit(1, 0);
        e_crce  = (crc_of(m_q) != d[31:16]);
        e_rcrce = e_crce;
        e_dfrm  = !e_crce;
      end
      m_in_frame = 0;
      m_q.delete();
    end else begin
      // Overlength payload, SOF, IDLE or BAD: abort.
      if (m_q.size() > 0) model_emit(1, 1);
      e_rfrme = 1;
      m_in_frame = is_sof;
      m_q.delete();
    end
  endtask

  task automatic compare_outputs();
    check_val("frm_vld",  32'(frm_vld),  32'(e_vld));
    check_val("frm_data", frm_data,      e_data);
    check_val("frm_last", 32'(frm_last), 32'(e_last));
    check_val("frm_crce", 32'(frm_crce), 32'(e_crce));
    check_val("frm_frme", 32'(frm_frme), 32'(e_frme));
    check_val("reg_dfrm", 32'(reg_dfrm), 32'(e_dfrm));
    check_val("reg_crce", 32'(reg_crce), 32'(e_rcrce));
    check_val("reg_frme", 32'(reg_frme), 32'(e_rfrme));
    check_val("reg_idsi", 32'(reg_idsi), 32'(e_idsi));
    o_vld   += int'(frm_vld);
    o_last  += int'(frm_last);
    o_crce  += int'(frm_crce);
    o_frme  += int'(frm_frme);
    o_dfrm  += int'(reg_dfrm);
    o_rcrce += int'(reg_crce);
    o_rfrme += int'(reg_frme);
  endtask

  task automatic clr_obs();
    o_vld = 0; o_last = 0; o_crce = 0; o_frme = 0;
    o_dfrm = 0; o_rcrce = 0; o_rfrme = 0;
  endtask

  // One link cycle: drive, predict, clock, compare.
  task automatic cyc(input logic [31:0] d, input logic [3:0] k, input logic v);
    hsl_data = d;
    hsl_kchr = k;
    hsl_vld  = v;
    model_step(d, k, v);
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic pl(input logic [31:0] d);
    cyc(d, 4'b0000, 1'b1);
  endtask

  task automatic sof();
    cyc(mk_ctrl(16'h0000, SOF_CHR), 4'b0001, 1'b1);
  endtask

  task automatic eof(input logic [15:0] c);
    cyc(mk_ctrl(c, EOF_CHR), 4'b0001, 1'b1);
  endtask

  task automatic gap();
    cyc(32'h0, 4'b0000, 1'b0);
  endtask

  task automatic do_reset();
    hsl_vld = 0;
    rst = 0;
    model_reset();
    #1;
    compare_outputs();
    @(posedge clk);
    #1;
    compare_outputs();
    rst = 1;
  endtask

  logic [31:0] fw[$];
  logic [15:0] good_crc;

  initial begin
    hsl_data = '0;
    hsl_kchr = '0;
    hsl_vld  = 0;
    rst      = 0;
    clr_obs();
    do_reset();
    gap();
    gap();

    // Idle sentinel
    clr_obs();
    cyc(mk_ctrl(16'hBEEF, IDLE_CHR), 4'b0001, 1'b1);
    check_val("idle_sentinel", 32'(reg_idsi), 32'h0000BEEF);
    check_val("idle_no_vld", 32'(o_vld), 0);

    // Good frame
    fw = '{32'h11111111, 32'h22222222, 32'h33333333};
    good_crc = crc_of(fw);
    clr_obs();
    sof();
    foreach (fw[i]) pl(fw[i]);
    eof(good_crc);
    gap();
    check_val("good_nvld", 32'(o_vld), 3);
    check_val("good_nlast", 32'(o_last), 1);
    check_val("good_ncrce", 32'(o_crce), 0);
    check_val("good_ndfrm", 32'(o_dfrm), 1);

    // CRC failure
    clr_obs();
    sof();
    foreach (fw[i]) pl(fw[i]);
    eof(good_crc ^ 16'h0001);
    gap();
    check_val("crc_nlast", 32'(o_last), 1);
    check_val("crc_ncrce", 32'(o_crce), 1);
    check_val("crc_nrcrce", 32'(o_rcrce), 1);
    check_val("crc_ndfrm", 32'(o_dfrm), 0);

    // Overlength
    clr_obs();
    sof();
    for (int i = 0; i < MAXW + 1; i++) pl(32'hA0000000 + 32'(i));
    eof(16'h0000);
    gap();
    check_val("ovl_nvld", 32'(o_vld), 16);
    check_val("ovl_nlast", 32'(o_last), 1);
    check_val("ovl_nfrme", 32'(o_frme), 1);
    check_val("ovl_nrfrme", 32'(o_rfrme), 1);
    check_val("ovl_ndfrm", 32'(o_dfrm), 0);

    // Gaps and clock-compensation words
    fw = '{32'hCAFE0001, 32'h12345678, 32'hFFFF0000};
    clr_obs();
    sof();
    pl(fw[0]);
    pl(fw[1]);
    repeat (5) gap();
    pl(fw[2]);
    cyc(32'hBCBCBCBC, 4'b1111, 1'b1);
    cyc(32'hBCBCBCBC, 4'b1111, 1'b1);
    eof(crc_of(fw));
    gap();
    check_val("gap_nvld", 32'(o_vld), 3);
    check_val("gap_ndfrm", 32'(o_dfrm), 1);

    // Reset mid-frame
    sof();
    pl(32'h01010101);
    pl(32'h02020202);
    clr_obs();
    do_reset();
    pl(32'h03030303);
    eof(16'h0000);
    gap();
    check_val("rst_nvld", 32'(o_vld), 0);
    check_val("rst_npulse", 32'(o_dfrm + o_rcrce + o_rfrme), 0);

    // EOF straight after SOF
    clr_obs();
    sof();
    eof(16'h0000);
    gap();
    check_val("empty_nrfrme", 32'(o_rfrme), 1);
    check_val("empty_nvld", 32'(o_vld), 0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 55) begin
        pl($urandom);
      end else if (r < 63) begin
        sof();
      end else if (r < 73) begin
        if ($urandom_range(0, 1) == 1 && m_in_frame) eof(crc_of(m_q));
        else eof(16'($urandom));
      end else if (r < 78) begin
        cyc(mk_ctrl(16'($urandom), IDLE_CHR), 4'b0001, 1'b1);
      end else if (r < 83) begin
        cyc($urandom, 4'b1111, 1'b1);
      end else if (r < 86) begin
        cyc(mk_ctrl(16'($urandom), 8'h55), 4'b0001, 1'b1);
      end else if (r < 88) begin
        cyc($urandom, 4'b0110, 1'b1);
      end else if (r < 99) begin
        cyc($urandom, 4'($urandom), 1'b0);
      end else begin
        do_reset();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
